// File: rtl/mips_pkg.sv
// Shared arbiter definitions: FSM state encoding, requester indices and
// the tie-break helper used by the memory port arbiter.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Requester indices, also the value driven on sel
  localparam logic REQ_DATA  = 1'b0;
  localparam logic REQ_INSTR = 1'b1;

  // Width of the access timeout counter
  localparam int unsigned CNT_W = 8;

  // A lone request wins outright; on a tie the requester that was not
  // served last wins.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end else if (r1) begin
      return REQ_INSTR;
    end else begin
      return REQ_DATA;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side signal bundle of the memory port arbiter.
// slave: the arbiter's view; master: requesters and memory driving it.
interface mem_port_arbiter_if #(
  parameter int unsigned W = 32
);

  logic         req0;
  logic [W-1:0] addr0;
  logic         req1;
  logic [W-1:0] addr1;
  logic         mem_ready;
  logic         mem_valid;
  logic [W-1:0] mem_addr;
  logic         sel;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         err;

  modport slave (
    input  req0, addr0, req1, addr1, mem_ready,
    output mem_valid, mem_addr, sel, gnt0, gnt1, done0, done1, err
  );

  modport master (
    output req0, addr0, req1, addr1, mem_ready,
    input  mem_valid, mem_addr, sel, gnt0, gnt1, done0, done1, err
  );

endinterface

// File: rtl/mux2in1.sv
// Generic two-input multiplexer: res = op1 when sel is high, else op2.
module mux2in1 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         sel,
  output logic [W-1:0] res
);

  // Select between the two operands
  always_comb begin
    res = sel ? op1 : op2;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: grants one requester at a time,
// holds the grant until memory completes or a timeout aborts the access,
// and chains straight into the next grant when requests are pending.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned TMO = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  // Counter value in the last BUSY cycle before a timeout fires
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic             busy;

  // Address path: owner's address routed to memory
  mux2in1 #(.W(W)) u_addr_mux (
    .op1 (bus.addr1),
    .op2 (bus.addr0),
    .sel (sel_q),
    .res (bus.mem_addr)
  );

  // State, owner, history, timeout counter and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= REQ_DATA;
      last_q  <= REQ_INSTR;
      cnt_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, completion and timeout decisions
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = BUSY;
          sel_d   = arb_pick(bus.req0, bus.req1, last_q);
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done0_d = (sel_q == REQ_DATA);
          done1_d = (sel_q == REQ_INSTR);
          last_d  = sel_q;
          // Back-to-back grant: the finishing owner is the new "last",
          // so the tie-break uses sel_q rather than the stale last_q.
          if (bus.req0 || bus.req1) begin
            sel_d = arb_pick(bus.req0, bus.req1, sel_q);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          last_d  = sel_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant and status outputs, all derived from registered state
  always_comb begin
    busy          = (state_q == BUSY);
    bus.mem_valid = busy;
    bus.sel       = sel_q;
    bus.gnt0      = busy && (sel_q == REQ_DATA);
    bus.gnt1      = busy && (sel_q == REQ_INSTR);
    bus.done0     = done0_q;
    bus.done1     = done1_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver plays access
// descriptors and queues the grant each should produce; an independent
// monitor matches every grant, address and completion pulse it observes.
module tb_mem_port_arbiter;

  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  mem_port_arbiter_if #(.W(W)) bus ();

  mem_port_arbiter #(.W(W), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One access request as issued by the driver
  typedef struct {
    logic         r0, r1;
    logic [W-1:0] a0, a1;
    int unsigned  d;     // BUSY cycle carrying mem_ready; > TMO means never
    bit           b2b;   // present the next descriptor in the completion cycle
    bit           drop;  // owner drops its request in BUSY cycle 1
    int unsigned  gap;   // idle cycles before an unchained issue
  } spec_t;

  // What the arbiter must show for one access
  typedef struct {
    logic         owner;
    logic [W-1:0] addr;
    int unsigned  start, len;
    bit           is_err, abort;
  } exp_t;

  spec_t spec_q[$];
  exp_t  exp_q[$];
  logic  m_last = 1'b1;

  exp_t  cur, ending;
  bit    active = 1'b0;
  bit    end_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic spec_t mk(input logic r0, input logic r1, input logic [W-1:0] a0,
                               input logic [W-1:0] a1, input int unsigned d, input bit b2b,
                               input bit drop, input int unsigned gap);
    spec_t s;
    s.r0 = r0; s.r1 = r1; s.a0 = a0; s.a1 = a1;
    s.d = d; s.b2b = b2b; s.drop = drop; s.gap = gap;
    return s;
  endfunction

  // Present a request set; the arbiter must grant it in the next cycle
  task automatic drive_issue(input spec_t s, output exp_t e);
    bus.req0  = s.r0;
    bus.req1  = s.r1;
    bus.addr0 = s.a0;
    bus.addr1 = s.a1;
    e.owner   = (s.r0 && s.r1) ? ~m_last : s.r1;
    e.addr    = e.owner ? s.a1 : s.a0;
    e.start   = cyc + 1;
    e.is_err  = (s.d > TMO);
    e.len     = e.is_err ? TMO : s.d;
    e.abort   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_specs();
    spec_t s, ns;
    exp_t  e, nxt;
    bit    chained = 1'b0;
    while (spec_q.size() != 0) begin
      s = spec_q.pop_front();
      if (chained) begin
        e = nxt;
      end else begin
        repeat (s.gap) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
          bus.mem_ready = 1'($urandom_range(0, 1));
          bus.addr0 = W'($urandom); bus.addr1 = W'($urandom);
          step();
        end
        bus.mem_ready = 1'($urandom_range(0, 1));
        drive_issue(s, e);
        step();
      end
      chained = 1'b0;
      for (int unsigned j = 1; j <= e.len; j++) begin
        if (!e.is_err && j == e.len) begin
          bus.mem_ready = 1'b1;
          m_last = e.owner;
          if (s.b2b && spec_q.size() != 0) begin
            ns = spec_q[0];
            if (e.owner) ns.a1 = e.addr; else ns.a0 = e.addr;
            spec_q[0] = ns;
            drive_issue(ns, nxt);
            chained = 1'b1;
          end else begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
          end
        end else begin
          bus.mem_ready = 1'b0;
          if (e.owner) begin
            if (j == 1 && s.drop) bus.req1 = 1'b0;
            bus.req0  = 1'($urandom_range(0, 1));
            bus.addr0 = W'($urandom);
          end else begin
            if (j == 1 && s.drop) bus.req0 = 1'b0;
            bus.req1  = 1'($urandom_range(0, 1));
            bus.addr1 = W'($urandom);
          end
        end
        step();
      end
      if (e.is_err) m_last = e.owner;
    end
  endtask

  // Monitor: pops an expectation whenever a grant appears, then checks it
  always @(negedge clk) begin : monitor
    logic [2:0] pexp;
    if (!rst_n) begin
      chk("reset_outputs", {bus.mem_valid, bus.sel, bus.gnt0, bus.gnt1,
                            bus.done0, bus.done1, bus.err}, '0);
      if (!cur.abort) chk("access_open_at_reset", active, 1'b0);
      active   = 1'b0;
      end_pend = 1'b0;
    end else begin
      pexp = '0;
      if (end_pend) pexp = ending.is_err ? 3'b001 : (ending.owner ? 3'b010 : 3'b100);
      chk("done0_done1_err", {bus.done0, bus.done1, bus.err}, pexp);
      end_pend = 1'b0;
      if (!active && bus.mem_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", bus.mem_valid, 1'b0);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          chk("grant_start_cycle", cyc, cur.start);
        end
      end
      if (active) begin
        chk("valid_sel_gnt", {bus.mem_valid, bus.sel, bus.gnt1, bus.gnt0},
            {1'b1, cur.owner, cur.owner, ~cur.owner});
        chk("mem_addr", bus.mem_addr, cur.addr);
        if (cyc - cur.start + 1 == cur.len) begin
          ending   = cur;
          end_pend = 1'b1;
          active   = 1'b0;
        end
      end else begin
        chk("idle_outputs", {bus.mem_valid, bus.gnt1, bus.gnt0}, '0);
      end
    end
  end

  initial begin
    exp_t e;
    int unsigned pick, dsel;
    cur.abort = 1'b0;
    rst_n = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Continuous ties, ready every BUSY cycle: 0,1,0,1 with no bubble
    for (int i = 0; i < 4; i++)
      spec_q.push_back(mk(1'b1, 1'b1, W'($urandom), W'($urandom), 1, (i < 3), 1'b0, 0));
    // Single data request, ready in BUSY cycle 2
    spec_q.push_back(mk(1'b1, 1'b0, W'(32'h40), W'($urandom), 2, 1'b0, 1'b0, 1));
    // Instruction fetch that never completes
    spec_q.push_back(mk(1'b0, 1'b1, W'($urandom), W'(32'h100), TMO + 1, 1'b0, 1'b0, 1));
    // Owner drops its request early, ready in cycle 3
    spec_q.push_back(mk(1'b1, 1'b0, W'($urandom), W'($urandom), 3, 1'b0, 1'b1, 1));
    // Ready in the very cycle the timeout would fire
    spec_q.push_back(mk(1'b1, 1'b1, W'($urandom), W'($urandom), TMO, 1'b0, 1'b0, 1));
    spec_q.push_back(mk(1'b0, 1'b1, W'($urandom), W'($urandom), TMO, 1'b1, 1'b0, 0));
    spec_q.push_back(mk(1'b1, 1'b0, W'($urandom), W'($urandom), 1, 1'b0, 1'b0, 0));
    run_specs();

    // Randomised traffic with boundary-weighted ready delays
    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(1, 3);
      dsel = $urandom_range(0, 5);
      spec_q.push_back(mk(pick[0], pick[1], W'($urandom), W'($urandom),
                          (dsel == 0) ? 1 : (dsel == 1) ? TMO : (dsel == 2) ? TMO + 1
                                      : $urandom_range(1, TMO),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 2)));
    end
    run_specs();

    // Reset in the middle of an access
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
    step();
    bus.req0  = 1'b1;
    bus.addr0 = W'(32'h0000_0abc);
    e.owner = 1'b0; e.addr = W'(32'h0000_0abc); e.start = cyc + 1;
    e.len = 1000; e.is_err = 1'b0; e.abort = 1'b1;
    exp_q.push_back(e);
    step();
    step();
    step();
    rst_n = 1'b0;
    m_last = 1'b1;
    bus.req1 = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    spec_q.push_back(mk(1'b1, 1'b1, W'($urandom), W'($urandom), 2, 1'b0, 1'b0, 0));
    run_specs();

    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) step();
    chk("expectations_drained", 64'(exp_q.size()), 64'd0);
    chk("no_open_access", {active, end_pend}, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 32, the address width in bits.
REQ-002 The block SHALL have parameter TMO, default 15, the maximum number of BUSY cycles to wait for mem_ready (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req0, input, 1 bit: requester 0 (data access) wants the port.
REQ-006 The block SHALL have port addr0, input, W bits: requester 0 address.
REQ-007 The block SHALL have port req1, input, 1 bit: requester 1 (instruction fetch) wants the port.
REQ-008 The block SHALL have port addr1, input, W bits: requester 1 address.
REQ-009 The block SHALL have port mem_ready, input, 1 bit: the memory completes the current access this cycle.
REQ-010 The block SHALL have port mem_valid, output, 1 bit: an access is presented to memory.
REQ-011 The block SHALL have port mem_addr, output, W bits: the selected address.
REQ-012 The block SHALL have port sel, output, 1 bit: current owner (0 = requester 0, 1 = requester 1).
REQ-013 The block SHALL have ports gnt0 and gnt1, outputs, 1 bit each: owner grant, held for the whole access.
REQ-014 The block SHALL have ports done0 and done1, outputs, 1 bit each: one-cycle completion pulse to the owner.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle timeout pulse.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-017 IDLE: if neither req is high, the FSM SHALL stay in IDLE with mem_valid = 0 and gnt0 = gnt1 = 0.
REQ-018 IDLE: if exactly one req is high, that requester SHALL win; on the next edge the FSM goes to BUSY with sel = winner, gnt_winner = 1 and mem_valid = 1.
REQ-019 Tie (req0 = req1 = 1): the winner SHALL be the requester other than last; last resets to 1, so requester 0 wins the first tie.
REQ-020 mem_addr SHALL be combinational: addr1 when sel = 1, addr0 when sel = 0; it is valid only while mem_valid = 1.
REQ-021 BUSY: sel and gnt SHALL stay constant.
REQ-022 BUSY: req deassertion and address changes by the owner SHALL be ignored; the owner must hold addr until done.
REQ-023 BUSY with mem_ready = 1: done_owner SHALL pulse on the next cycle and last SHALL be set to owner.
REQ-024 Same BUSY/mem_ready cycle, back-to-back: arbitration SHALL run on the current req inputs, so the next grant begins the following cycle with no IDLE bubble; otherwise the FSM returns to IDLE.
REQ-025 Timeout counter: an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-026 Timeout abort: when the counter reaches TMO without mem_ready, err SHALL pulse one cycle, no done pulse is issued, last is set to owner and the FSM goes to IDLE.
REQ-027 mem_ready SHALL be ignored when mem_valid = 0.
REQ-028 mem_ready in the same cycle the counter reaches TMO SHALL count as completion, not timeout.
REQ-029 done0, done1 and err SHALL be mutually exclusive.
REQ-030 gnt0 and gnt1 SHALL never be high together.
REQ-031 Latency SHALL be 1 cycle from req to gnt/mem_valid.

Reset
REQ-032 While rst_n = 0, regardless of clock: state = IDLE; gnt0, gnt1, done0, done1, err, mem_valid = 0; sel = 0; last = 1; counter = 0.
REQ-033 Reset asserted mid-access SHALL abort the access without a done or err pulse.
REQ-034 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-035 State encoding (IDLE, BUSY) and the requester-index constants SHALL live in the shared package mips_pkg.
REQ-036 The address selection SHALL instantiate the existing mux2in1 with W = W, op1 = addr1, op2 = addr0, sel = sel.
REQ-037 No other sub-module SHALL be used.

Verification
REQ-038 Single request: req0 = 1, addr0 = 0x0000_0040, mem_ready on BUSY cycle 2 -> gnt0 and mem_valid high for 2 cycles, mem_addr = 0x40, done0 pulses once.
REQ-039 Ties: req0 = req1 = 1 continuously, mem_ready = 1 every BUSY cycle -> grants alternate 0,1,0,1 with no IDLE cycles between them.
REQ-040 Timeout: req1 = 1, addr1 = 0x100, mem_ready never asserted -> err pulses after exactly 15 BUSY cycles, no done1, FSM returns to IDLE.
REQ-041 Reset mid-access: rst_n low during BUSY cycle 3 -> all outputs 0 immediately, no done or err pulse; after release, req0 = req1 = 1 -> requester 0 wins.
REQ-042 Owner drops request: req0 dropped in BUSY cycle 1, mem_ready in cycle 3 -> gnt0 is held and done0 still pulses.
REQ-043 Boundary: mem_ready arrives in the same cycle the counter reaches TMO -> done pulses and err stays 0.
